// File: rtl/load_store_unit_if.sv
// Request/acknowledge data-memory bus between the load/store unit (master)
// and the data memory (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: issues byte-masked bus writes and aligned/extended reads,
// stalls the pipeline while an access is outstanding, flags bad accesses and timeouts.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [2:0]          funct3,
  input  logic [31:0]         addr,
  input  logic [31:0]         WriteData,
  output logic [31:0]         ReadData,
  output logic                stall,
  output logic                misaligned,
  output logic                bus_err,
  load_store_unit_if.master   bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       f3_reg;
  logic [1:0]       off_reg;

  logic        acc, is_store, f3_ok, align_ok;
  logic        issue, reject, ack_done, timeout_hit;
  logic [3:0]  be_issue;
  logic [31:0] wdata_issue;
  logic [31:0] byte_word;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Request decode: a store wins when both MemRead and MemWrite are set.
  always_comb begin
    acc      = MemRead | MemWrite;
    is_store = MemWrite;
    if (is_store)
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    be_issue    = 4'b1111;
    wdata_issue = WriteData;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_issue    = 4'b0001 << addr[1:0];
          wdata_issue = {4{WriteData[7:0]}};
        end
        2'b01: begin
          be_issue    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_issue = {2{WriteData[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load extraction uses the offset and width captured at issue time.
  always_comb begin
    byte_word = bus.mem_rdata >> {off_reg, 3'b000};
    half_sel  = off_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_reg)
      3'b000:  load_data = {{24{byte_word[7]}}, byte_word[7:0]};
      3'b100:  load_data = {24'h0, byte_word[7:0]};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    stall       = 1'b0;
    issue       = 1'b0;
    reject      = 1'b0;
    ack_done    = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (acc) begin
          if (f3_ok && align_ok) begin
            issue      = 1'b1;
            stall      = 1'b1;
            state_next = REQ;
          end else begin
            reject = 1'b1;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        // An ack in the same cycle the counter expires still completes normally.
        if (bus.mem_ack) begin
          ack_done   = 1'b1;
          state_next = DONE;
        end else if (cnt_reg == TIMEOUT_C) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      f3_reg        <= '0;
      off_reg       <= '0;
      ReadData      <= '0;
      misaligned    <= 1'b0;
      bus_err       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state_reg  <= state_next;
      misaligned <= reject;
      bus_err    <= timeout_hit;
      if (issue) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= is_store;
        bus.mem_addr  <= {addr[31:2], 2'b00};
        bus.mem_be    <= be_issue;
        bus.mem_wdata <= wdata_issue;
        f3_reg        <= funct3;
        off_reg       <= addr[1:0];
        cnt_reg       <= CNT_W'(1);
      end else if (state_reg == REQ) begin
        if (ack_done || timeout_hit) begin
          bus.mem_req <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        if (ack_done && !bus.mem_we)
          ReadData <= load_data;
        if (timeout_hit && !bus.mem_we)
          ReadData <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a bus responder and a ReadData scoreboard.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        stall, misaligned, bus_err;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .addr       (addr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_cyc;   // REQ cycle carrying the ack; 0 = never
    logic        misal;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;    // loads only
  } vec_t;

  vec_t        vt[18];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic vec_t mk(string name, logic mr, logic mw, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rdata,
                              int ack_cyc, logic misal, logic [3:0] be,
                              logic [31:0] exp_wdata, logic [31:0] exp_rd);
    vec_t v;
    v.name = name; v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = a; v.wd = wd;
    v.rdata = rdata; v.ack_cyc = ack_cyc; v.misal = misal; v.be = be;
    v.exp_wdata = exp_wdata; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000; addr = '0; WriteData = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    int   stall_cnt;
    int   exp_req;
    logic exp_err;
    logic ended;
    exp_err = !(v.ack_cyc >= 1 && v.ack_cyc <= TO);
    exp_req = exp_err ? TO : v.ack_cyc;
    MemRead = v.mr; MemWrite = v.mw; funct3 = v.f3; addr = v.addr; WriteData = v.wd;
    #1;
    if (v.misal) begin
      chk({v.name, "_stall"}, {31'b0, stall}, 32'd0);
      tick;
      clear_inputs;
      chk({v.name, "_misal"}, {31'b0, misaligned}, 32'd1);
      chk({v.name, "_noreq"}, {31'b0, bus.mem_req}, 32'd0);
      tick;
      chk({v.name, "_misal_end"}, {31'b0, misaligned}, 32'd0);
      $display("txn %s: rejected, misaligned=%0b", v.name, misaligned);
      return;
    end
    chk({v.name, "_issue_stall"}, {31'b0, stall}, 32'd1);
    if (!v.mw) last_rd = v.exp_rd;
    exp_q.push_back(last_rd);
    stall_cnt = 1;
    tick;
    clear_inputs;
    cyc = 1;
    ended = 1'b0;
    while (!ended) begin
      chk({v.name, "_req"}, {31'b0, bus.mem_req}, 32'd1);
      chk({v.name, "_addr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
      chk({v.name, "_we"}, {31'b0, bus.mem_we}, {31'b0, v.mw});
      chk({v.name, "_be"}, {28'b0, bus.mem_be}, {28'b0, v.be});
      if (v.mw) chk({v.name, "_wdata"}, bus.mem_wdata, v.exp_wdata);
      if (stall) stall_cnt++;
      bus.mem_ack = (cyc == v.ack_cyc);
      bus.mem_rdata = (cyc == v.ack_cyc) ? v.rdata : $urandom;
      tick;
      bus.mem_ack = 1'b0;
      if (!stall) ended = 1'b1;
      else begin
        cyc++;
        if (cyc > 40) begin
          chk({v.name, "_req_bound"}, 32'd1, 32'd0);
          return;
        end
      end
    end
    chk({v.name, "_done_req"}, {31'b0, bus.mem_req}, 32'd0);
    chk({v.name, "_bus_err"}, {31'b0, bus_err}, {31'b0, exp_err});
    chk({v.name, "_stall_cycles"}, stall_cnt, exp_req + 1);
    if (exp_q.size() == 0) chk({v.name, "_queue_empty"}, 32'd1, 32'd0);
    else chk({v.name, "_rdata"}, ReadData, exp_q.pop_front());
    tick;
    chk({v.name, "_err_end"}, {31'b0, bus_err}, 32'd0);
    chk({v.name, "_idle_stall"}, {31'b0, stall}, 32'd0);
    $display("txn %s: addr=%h be=%b we=%0b ReadData=%h bus_err_seen=%0b stalls=%0d",
             v.name, v.addr, v.be, v.mw, ReadData, exp_err, stall_cnt);
  endtask

  initial begin
    vt[0]  = mk("lw_100",   1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1, 0, 4'b1111, 0, 32'hDEADBEEF);
    vt[1]  = mk("lb_103",   1, 0, 3'b000, 32'h103, 0, 32'h80112233, 1, 0, 4'b1111, 0, 32'hFFFFFF80);
    vt[2]  = mk("lbu_103",  1, 0, 3'b100, 32'h103, 0, 32'h80112233, 1, 0, 4'b1111, 0, 32'h00000080);
    vt[3]  = mk("lh_102",   1, 0, 3'b001, 32'h102, 0, 32'h80112233, 1, 0, 4'b1111, 0, 32'hFFFF8011);
    vt[4]  = mk("lhu_102",  1, 0, 3'b101, 32'h102, 0, 32'h80112233, 2, 0, 4'b1111, 0, 32'h00008011);
    vt[5]  = mk("lbu_101",  1, 0, 3'b100, 32'h101, 0, 32'h80112233, 1, 0, 4'b1111, 0, 32'h00000022);
    vt[6]  = mk("sb_201",   0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 2, 0, 4'b0010, 32'hABABABAB, 0);
    vt[7]  = mk("sh_202",   0, 1, 3'b001, 32'h202, 32'h00001234, 0, 1, 0, 4'b1100, 32'h12341234, 0);
    vt[8]  = mk("sw_300",   0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 3, 0, 4'b1111, 32'hCAFEF00D, 0);
    vt[9]  = mk("rw_sb403", 1, 1, 3'b000, 32'h403, 32'h0000005A, 0, 1, 0, 4'b1000, 32'h5A5A5A5A, 0);
    vt[10] = mk("lw_102",   1, 0, 3'b010, 32'h102, 0, 0, 1, 1, 0, 0, 0);
    vt[11] = mk("sh_101",   0, 1, 3'b001, 32'h101, 0, 0, 1, 1, 0, 0, 0);
    vt[12] = mk("ld_f3_011",1, 0, 3'b011, 32'h100, 0, 0, 1, 1, 0, 0, 0);
    vt[13] = mk("st_f3_100",0, 1, 3'b100, 32'h100, 0, 0, 1, 1, 0, 0, 0);
    vt[14] = mk("lw_timeout",1,0, 3'b010, 32'h500, 0, 32'h55555555, 0, 0, 4'b1111, 0, 32'h0);
    vt[15] = mk("lw_ack_last",1,0,3'b010, 32'h504, 0, 32'h11223344, TO, 0, 4'b1111, 0, 32'h11223344);
    vt[16] = mk("sw_timeout",0, 1, 3'b010, 32'h508, 32'h01020304, 0, 0, 0, 4'b1111, 32'h01020304, 0);
    vt[17] = mk("lh_pos",   1, 0, 3'b001, 32'h100, 0, 32'h00007FFF, 1, 0, 4'b1111, 0, 32'h00007FFF);

    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    last_rd = '0;

    rst_n = 1'b0;
    tick;
    tick;
    chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_misal", {31'b0, misaligned}, 32'd0);
    chk("rst_buserr", {31'b0, bus_err}, 32'd0);
    chk("rst_be", {28'b0, bus.mem_be}, 32'd0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 18; i++) run_vec(vt[i]);

    // Reset in the middle of a load, then a stray ack, then a clean load.
    MemRead = 1'b1; funct3 = 3'b010; addr = 32'h600;
    tick;
    clear_inputs;
    chk("mid_req", {31'b0, bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mid_rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    chk("mid_rst_rdata", ReadData, 32'd0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF0000;
    tick;
    bus.mem_ack = 1'b0;
    chk("late_ack_req", {31'b0, bus.mem_req}, 32'd0);
    chk("late_ack_stall", {31'b0, stall}, 32'd0);
    chk("late_ack_rdata", ReadData, 32'd0);
    $display("txn mid_reset: mem_req=%0b ReadData=%h after late ack", bus.mem_req, ReadData);
    last_rd = '0;
    run_vec(mk("lw_after_rst", 1, 0, 3'b010, 32'h600, 0, 32'h0BADF00D, 1, 0, 4'b1111, 0, 32'h0BADF00D));

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
